// File: rtl/apb_slave_mem.sv
// APB completer backed by a word-addressed register array.
// It inserts a fixed number of wait states and returns an error for bad addresses.
module apb_slave_mem #(
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter int unsigned           DEPTH       = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int unsigned           WAIT_STATES = 0
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  psel,
   input  logic                  penable,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic                  pwrite,
   input  logic [DATA_WIDTH-1:0] pwdata,
   output logic [DATA_WIDTH-1:0] prdata,
   output logic                  pready,
   output logic                  pslverr
);

   localparam int unsigned           IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(DEPTH * 4);
   localparam logic [3:0]            WS    = 4'(WAIT_STATES);

   typedef enum logic {StIdle, StAccess} state_e;

   state_e                state_q;
   logic [3:0]            cnt_q;
   logic [IDX_W-1:0]      idx_q;
   logic                  wr_q;
   logic                  err_q;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [ADDR_WIDTH-1:0] offset;
   logic [IDX_W-1:0]      dec_idx;
   logic                  dec_err;
   logic                  mem_we;

   always_comb begin
      offset  = paddr - BASE_ADDR;
      dec_idx = offset[IDX_W+1:2];
      dec_err = (paddr[1:0] != 2'b00) || (paddr < BASE_ADDR) || (offset >= SPAN);
   end

   // Direction for the commit is taken from pwrite in the completion cycle itself.
   assign mem_we = (state_q == StAccess) && psel && pready && pwrite && !err_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         pready  <= 1'b0;
         pslverr <= 1'b0;
         prdata  <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (psel && !penable) begin
                  state_q <= StAccess;
                  cnt_q   <= WS;
                  idx_q   <= dec_idx;
                  wr_q    <= pwrite;
                  err_q   <= dec_err;
                  // Zero-wait: the setup edge already produces the response.
                  if (WAIT_STATES == 0) begin
                     pready  <= 1'b1;
                     pslverr <= dec_err;
                     prdata  <= (pwrite || dec_err) ? '0 : mem_q[dec_idx];
                  end
               end
            end
            StAccess: begin
               if (!psel || pready) begin
                  state_q <= StIdle;
                  cnt_q   <= '0;
                  pready  <= 1'b0;
                  pslverr <= 1'b0;
                  prdata  <= '0;
               end else if (penable) begin
                  cnt_q <= cnt_q - 4'd1;
                  if (cnt_q == 4'd1) begin
                     pready  <= 1'b1;
                     pslverr <= err_q;
                     prdata  <= (wr_q || err_q) ? '0 : mem_q[idx_q];
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (mem_we) begin
         mem_q[idx_q] <= pwdata;
      end
   end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: three instances with 0, 2 and 3 wait states share one bus,
// checked against an array model of the word store and the address-error rules.
module tb_apb_slave_mem;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [2:0]  psel_v = '0;
   logic        penable = 1'b0;
   logic [31:0] paddr = '0;
   logic        pwrite = 1'b0;
   logic [31:0] pwdata = '0;
   logic [31:0] prdata0, prdata1, prdata2;
   logic [2:0]  pready_v, pslverr_v;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] model [3][16];

   always #5 clk = ~clk;

   apb_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .BASE_ADDR(32'h0),
                   .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .resetn(resetn), .psel(psel_v[0]), .penable(penable), .paddr(paddr),
      .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata0), .pready(pready_v[0]),
      .pslverr(pslverr_v[0]));

   apb_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .BASE_ADDR(32'h0),
                   .WAIT_STATES(2)) u_ws2 (
      .clk(clk), .resetn(resetn), .psel(psel_v[1]), .penable(penable), .paddr(paddr),
      .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata1), .pready(pready_v[1]),
      .pslverr(pslverr_v[1]));

   apb_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .BASE_ADDR(32'h0),
                   .WAIT_STATES(3)) u_ws3 (
      .clk(clk), .resetn(resetn), .psel(psel_v[2]), .penable(penable), .paddr(paddr),
      .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata2), .pready(pready_v[2]),
      .pslverr(pslverr_v[2]));

   function automatic int ws_of(input int d);
      case (d)
         0:       return 0;
         1:       return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic [31:0] rd_of(input int d);
      case (d)
         0:       return prdata0;
         1:       return prdata1;
         default: return prdata2;
      endcase
   endfunction

   // 16 words at base 0: legal addresses are word-aligned and below 64.
   function automatic logic exp_err(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a >= 32'd64);
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic clear_model();
      for (int d = 0; d < 3; d++)
         for (int i = 0; i < 16; i++) model[d][i] = '0;
   endtask

   // Called at posedge+1; returns at posedge+1 after the completion edge.
   task automatic apb_xfer(input int d, input logic w, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] rd, output logic err,
                           output int waits, output logic done, output logic leak);
      psel_v[d] = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = wd;
      @(posedge clk); #1;
      penable = 1'b1;
      waits = 0; done = 1'b0; leak = 1'b0; rd = '0; err = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (pready_v[d]) begin
            rd = rd_of(d); err = pslverr_v[d]; done = 1'b1;
         end else begin
            if (rd_of(d) != 32'h0 || pslverr_v[d]) leak = 1'b1;
            waits++;
         end
         @(posedge clk); #1;
      end
      psel_v[d] = 1'b0; penable = 1'b0;
   endtask

   task automatic do_op(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] wd);
      logic [31:0] rd;
      logic        err, done, leak, e;
      int          waits;
      apb_xfer(d, w, a, wd, rd, err, waits, done, leak);
      e = exp_err(a);
      check_eq("completed", 32'(done), 32'd1);
      check_eq("wait_cycles", waits, ws_of(d));
      check_eq("pslverr", 32'(err), 32'(e));
      check_eq("zero_while_not_ready", 32'(leak), 32'd0);
      if (!w) check_eq("prdata", rd, e ? 32'h0 : model[d][a[5:2]]);
      else if (!e) model[d][a[5:2]] = wd;
   endtask

   initial begin
      logic        seen, done;
      int          d;
      logic        w;
      logic [31:0] a;

      clear_model();
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_pready", 32'(pready_v), 32'h0);
      check_eq("reset_pslverr", 32'(pslverr_v), 32'h0);
      check_eq("reset_prdata", prdata0 | prdata1 | prdata2, 32'h0);
      @(negedge clk); resetn = 1'b1;
      @(posedge clk); #1;

      // Zero-wait write then read.
      do_op(0, 1'b1, 32'h8, 32'hDEAD_BEEF);
      do_op(0, 1'b0, 32'h8, 32'h0);

      // Three wait states.
      do_op(2, 1'b1, 32'h4, 32'hCAFE_F00D);
      do_op(2, 1'b0, 32'h4, 32'h0);

      // Error responses leave the array untouched.
      do_op(0, 1'b1, 32'h0, 32'h1234_5678);
      do_op(0, 1'b1, 32'h4, 32'h0BAD_F00D);
      do_op(0, 1'b1, 32'h40, 32'hFFFF_FFFF);
      do_op(0, 1'b1, 32'h6, 32'hEEEE_EEEE);
      do_op(0, 1'b0, 32'h4, 32'h0);
      do_op(0, 1'b0, 32'h0, 32'h0);
      do_op(0, 1'b0, 32'h40, 32'h0);

      // Back-to-back writes with no idle cycle in between.
      do_op(0, 1'b1, 32'h0, 32'h1111_1111);
      do_op(0, 1'b1, 32'hC, 32'h2222_2222);
      do_op(0, 1'b0, 32'h0, 32'h0);
      do_op(0, 1'b0, 32'hC, 32'h0);

      // Abort: psel dropped after one access cycle.
      do_op(1, 1'b1, 32'h10, 32'h0000_0077);
      psel_v[1] = 1'b1; penable = 1'b0; paddr = 32'h10; pwrite = 1'b1; pwdata = 32'h5555_5555;
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk);
      check_eq("abort_first_access_not_ready", 32'(pready_v[1]), 32'd0);
      @(posedge clk); #1;
      psel_v[1] = 1'b0; penable = 1'b0;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (pready_v[1]) seen = 1'b1;
      end
      check_eq("abort_no_pready", 32'(seen), 32'd0);
      @(posedge clk); #1;
      do_op(1, 1'b0, 32'h10, 32'h0);

      // penable without a setup cycle is ignored.
      psel_v[0] = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'hBAD0_BAD0;
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (pready_v[0]) seen = 1'b1;
      end
      @(posedge clk); #1;
      psel_v[0] = 1'b0; penable = 1'b0;
      check_eq("no_setup_no_response", 32'(seen), 32'd0);
      do_op(0, 1'b0, 32'h0, 32'h0);

      // Randomized traffic, occasionally separated by idle cycles.
      for (int n = 0; n < 300; n++) begin
         d = $urandom_range(0, 2);
         w = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) < 8) a = 32'($urandom_range(0, 15)) << 2;
         else a = 32'($urandom_range(0, 95));
         do_op(d, w, a, $urandom);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end

      // Reset asserted in the completion cycle of a read.
      do_op(2, 1'b1, 32'h0, 32'hABCD_1234);
      psel_v[2] = 1'b1; penable = 1'b0; paddr = 32'h0; pwrite = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (pready_v[2]) done = 1'b1;
      end
      check_eq("pre_reset_prdata", prdata2, 32'hABCD_1234);
      resetn = 1'b0;
      #1;
      check_eq("async_reset_pready", 32'(pready_v), 32'h0);
      check_eq("async_reset_pslverr", 32'(pslverr_v), 32'h0);
      check_eq("async_reset_prdata", prdata2, 32'h0);
      psel_v = '0; penable = 1'b0;
      clear_model();
      @(posedge clk);
      @(negedge clk); resetn = 1'b1;
      @(posedge clk); #1;
      do_op(2, 1'b0, 32'h0, 32'h0);
      do_op(0, 1'b0, 32'h8, 32'h0);
      do_op(1, 1'b0, 32'h10, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
